uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, the inbound counterpart of the existing `tx` serial output on the dsp top level. It samples an asynchronous 8N1 serial line and writes each good byte into a small first-word-fall-through FIFO. CPU/peripheral logic pops bytes through a read-strobe interface. Sticky error flags report framing and overflow conditions.

Parameters:
- DIVISOR, 104: clock cycles per bit; must be ≥ 8. The default gives 115200 baud at a 12 MHz `ck`.
- DEPTH, 16: FIFO depth in bytes; must be a power of 2 and ≥ 2.

Ports:
- ck  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- rx  in  1  serial input, idle high; asynchronous to `ck`.
- rd  in  1  pop strobe, one byte per cycle while high.
- rd_data  out  8  FIFO head byte; valid while `ready`=1.
- ready  out  1  FIFO not empty.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- frame_err  out  1  sticky; a stop bit was sampled low.
- overflow  out  1  sticky; a byte was dropped because the FIFO was full.
- clr  in  1  synchronous clear of `frame_err` and `overflow` (and `parity_err` when built in).

Behaviour:
- Reset values: `ready`=0, `count`=0, `rd_data`=0, all flags=0, FSM=IDLE, synchronizer flops=1, bit counter=0. Asserting `rst` mid-frame abandons the partial byte.
- `rx` passes through a 2-flop synchronizer. All FSM decisions use the synchronized value `rxs`.
- IDLE:
  - On `rxs`=0, load the bit timer with DIVISOR/2-1 and go to START.
- START:
  - When the timer expires, sample `rxs`.
  - If 0, load DIVISOR-1 and go to DATA.
  - If 1, treat it as a glitch and return to IDLE; nothing is written.
- DATA:
  - At each timer expiry, sample `rxs` into the shift register LSB first and reload DIVISOR-1.
  - After 8 samples, go to STOP.
- STOP:
  - At timer expiry, sample `rxs`.
  - If 1: push the byte and go to IDLE.
  - If 0: set `frame_err`, discard the byte, and go to BREAK.
- BREAK:
  - Wait for `rxs`=1, then go to IDLE. This prevents a held-low line being decoded as 0x00 frames.
- Latency: the pushed byte is visible at `rd_data` with `ready`=1 on the cycle after the mid-stop-bit sample.
- FIFO:
  - Implemented as a register array with write/read pointers one bit wider than the address, so they wrap modulo DEPTH.
  - `rd_data` is combinational from mem[rd_ptr].
- Push when full (`count`==DEPTH) with no simultaneous pop: drop the byte, set `overflow`, leave the contents unchanged.
- Push and pop in the same cycle:
  - Both take effect and `count` is unchanged.
  - When full, the push is accepted and `overflow` is not set.
  - When empty, only the push occurs: the pop is ignored and `count` becomes 1.
- Pop when empty is ignored; no pointer movement and no error.
- Flag update precedence: if `clr` coincides with a new error event, the flag ends set; the set wins.
- No baud-rate adaptation. The receiver tolerates up to about ±4% clock mismatch by sampling at mid-bit.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - The frame is 8E1: a PARITY state follows DATA and samples one bit.
  - If the XOR of the 8 data bits and the parity bit is 1, set the sticky output `parity_err` (1 bit, reset 0, cleared by `clr`) and discard the byte.
  - STOP checking is unchanged.
- When undefined: there is no `parity_err` port and no PARITY state; the frame is 8N1.

Test Plan:
- DIVISOR=16, DEPTH=4:
  - Send 0x55, then 0xA3 → after each stop bit `ready`=1 and `count` steps 1, 2.
  - Pop twice → `rd_data` is 0x55 then 0xA3; `ready`=0 and `count`=0.
- Low glitch on `rx` of 4 cycles (less than DIVISOR/2) → FSM returns to IDLE, `count` stays 0, no flags set.
- Frame 0x3C with stop bit forced 0 → `frame_err`=1 and `count`=0. Then hold `rx` low for 200 cycles, release, send 0x7E → `count`=1 and `rd_data`=0x7E. Pulse `clr` → `frame_err`=0.
- Send 0x01..0x05 with no reads → `count`=4, `overflow`=1, pops return 0x01..0x04.
  - Repeat with `rd` pulsed on the exact push cycle of the 5th byte while full → `overflow`=0 and the FIFO holds 0x02..0x05.
- Assert `rst` during data bit 4 of 0xF0, release, then send 0x81 → only 0x81 is received, `count`=1.
- With UART_RX_PARITY_EN:
  - Send 0x07 with parity bit 1 (correct even parity) → received.
  - Send 0x07 with parity bit 0 → `parity_err`=1 and `count` unchanged.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized 8N1 deserializer feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to build the 8E1 variant with a PARITY state and the parity_err flag.
module uart_rx #(
    parameter int DIVISOR = 104,
    parameter int DEPTH   = 16
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic                     rx,
    input  logic                     rd,
    input  logic                     clr,
    output logic [7:0]               rd_data,
    output logic                     ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_err,
    output logic                     overflow,
`ifdef UART_RX_PARITY_EN
    output logic                     parity_err,
`endif
    output logic [2:0]               fsm_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(DIVISOR);
    localparam logic [TW-1:0] FULL_BIT = TW'(DIVISOR - 1);
    localparam logic [TW-1:0] HALF_BIT = TW'(DIVISOR / 2 - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          sync1, rxs;
    logic          push, frame_set;
    logic          tick;
`ifdef UART_RX_PARITY_EN
    logic          par_bad, par_bad_n;
    logic          par_set;
`endif

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

    assign tick      = (timer == '0);
    assign fsm_state = state;

    // Timer counts down to zero; every expiry lands on the middle of a bit cell.
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
        par_set   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rxs) begin
                    timer_n = HALF_BIT;
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    if (!rxs) begin
                        timer_n   = FULL_BIT;
                        bit_cnt_n = 3'd0;
                        state_n   = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n = {rxs, shift[7:1]};
                    timer_n = FULL_BIT;
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_n = 3'd0;
`ifdef UART_RX_PARITY_EN
                        state_n   = PARITY;
`else
                        state_n   = STOP;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_bad_n = (^shift) ^ rxs;
                    par_set   = (^shift) ^ rxs;
                    timer_n   = FULL_BIT;
                    state_n   = STOP;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (rxs) begin
`ifdef UART_RX_PARITY_EN
                        push = !par_bad;
`else
                        push = 1'b1;
`endif
                        state_n = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_n   = BREAK;
                    end
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            // A line held low must not be decoded as a stream of 0x00 frames.
            BREAK: begin
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_n;
`endif
        end
    end

    // FIFO: pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, do_pop, do_push, ovf_set;

    assign count   = wr_ptr - rd_ptr;
    assign ready   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = rd && ready;
    assign do_push = push && (!full || do_pop);
    assign ovf_set = push && full && !do_pop;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= shift;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // A new error event beats a coincident clear.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err  <= frame_set | (frame_err & ~clr);
            overflow   <= ovf_set   | (overflow  & ~clr);
`ifdef UART_RX_PARITY_EN
            parity_err <= par_set   | (parity_err & ~clr);
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven bit by bit, expected bytes queued and checked on every pop.
module tb_uart_rx;

    localparam int D   = 16;
    localparam int DEP = 4;
    localparam int CW  = $clog2(DEP) + 1;

    logic          ck  = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          rd  = 1'b0;
    logic          clr = 1'b0;
    logic [7:0]    rd_data;
    logic          ready;
    logic [CW-1:0] count;
    logic          frame_err;
    logic          overflow;
    logic [2:0]    fsm_state;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    logic [7:0] exp_q[$];
    bit         exp_frame, exp_ovf, exp_par;
    int         errors = 0;
    int         checks = 0;

    uart_rx #(.DIVISOR(D), .DEPTH(DEP)) dut (
        .ck        (ck),
        .rst       (rst),
        .rx        (rx),
        .rd        (rd),
        .clr       (clr),
        .rd_data   (rd_data),
        .ready     (ready),
        .count     (count),
        .frame_err (frame_err),
        .overflow  (overflow),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .fsm_state (fsm_state)
    );

    // clock / watchdog
    always #5 ck = ~ck;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: every accepted pop must return the oldest expected byte
    always @(negedge ck) begin
        if (!rst && rd && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected none", rd_data);
            end else begin
                check("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_state(input string tag);
        check({tag, "_count"},     32'(count),     32'(exp_q.size()));
        check({tag, "_ready"},     32'(ready),     32'(exp_q.size() != 0));
        check({tag, "_frame_err"}, 32'(frame_err), 32'(exp_frame));
        check({tag, "_overflow"},  32'(overflow),  32'(exp_ovf));
`ifdef UART_RX_PARITY_EN
        check({tag, "_parity_err"}, 32'(parity_err), 32'(exp_par));
`endif
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic cyc(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic pop(input int n);
        repeat (n) begin
            rd = 1'b1;
            cyc(1);
            rd = 1'b0;
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        exp_frame = 1'b0;
        exp_ovf   = 1'b0;
        exp_par   = 1'b0;
    endtask

    // The mid-stop-bit sample lands on the (D/2+3)th edge after the stop bit starts.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                              input bit pop_at_push, input bit clr_at_push);
        logic [10:0] bits;
        int          nb;
        bit          good;
        bits    = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
        nb       = 11;
        bits[9]  = (^d) ^ !par_ok;
        bits[10] = stop_ok;
`else
        nb       = 10;
        bits[9]  = stop_ok;
`endif
        good = stop_ok && par_ok;
        for (int i = 0; i < nb - 1; i++) begin
            rx = bits[i];
            cyc(D);
        end
        rx = bits[nb-1];
        repeat (D/2 + 2) @(posedge ck);
        #1;
        if (pop_at_push) rd = 1'b1;
        if (clr_at_push) clr = 1'b1;
        if (!pop_at_push) begin
            @(negedge ck);
            check("pre_push_count", 32'(count), 32'(exp_q.size()));
        end
        @(posedge ck);
        #1;
        rd  = 1'b0;
        clr = 1'b0;
        if (clr_at_push) begin
            exp_frame = 1'b0;
            exp_ovf   = 1'b0;
            exp_par   = 1'b0;
        end
        if (!par_ok)  exp_par   = 1'b1;
        if (!stop_ok) exp_frame = 1'b1;
        if (good) begin
            if (exp_q.size() < DEP) exp_q.push_back(d);
            else exp_ovf = 1'b1;
        end
        @(negedge ck);
        check_state("post_push");
        repeat (D - (D/2 + 3)) @(posedge ck);
        #1;
        if (stop_ok) cyc(2);
    endtask

    initial begin
        bit          s_ok, p_ok;
        logic [7:0]  rb;

        // reset state
        cyc(3);
        @(negedge ck);
        check("rst_rd_data", 32'(rd_data),   32'(0));
        check("rst_fsm",     32'(fsm_state), 32'(0));
        check_state("rst");
        cyc(1);
        rst = 1'b0;
        cyc(4);

        // two bytes, then drain
        send_frame(8'h55, 1, 1, 0, 0);
        send_frame(8'hA3, 1, 1, 0, 0);
        pop(2);
        @(negedge ck);
        check_state("drain");

        // pop while empty is ignored
        pop(1);
        @(negedge ck);
        check_state("empty_pop");

        // short low glitch
        cyc(1);
        rx = 1'b0;
        cyc(4);
        rx = 1'b1;
        cyc(20);
        @(negedge ck);
        check_state("glitch");
        check("glitch_fsm_idle", 32'(fsm_state), 32'(0));

        // framing error then held-low line
        cyc(1);
        send_frame(8'h3C, 0, 1, 0, 0);
        cyc(200);
        @(negedge ck);
        check_state("break_hold");
        cyc(1);
        rx = 1'b1;
        cyc(4);
        send_frame(8'h7E, 1, 1, 0, 0);
        pop(1);
        do_clr();
        @(negedge ck);
        check_state("after_clr");
        cyc(1);

        // overflow without reads
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1, 1, 0, 0);
        pop(DEP);
        do_clr();

        // pop on the push cycle while full
        for (int b = 1; b <= 4; b++) send_frame(8'(b), 1, 1, 0, 0);
        send_frame(8'h05, 1, 1, 1, 0);
        pop(DEP);
        @(negedge ck);
        check_state("simul_drain");
        cyc(1);

        // clear coinciding with a framing error: the set wins, overflow clears
        for (int b = 1; b <= 5; b++) send_frame(8'(b + 16), 1, 1, 0, 0);
        send_frame(8'h99, 0, 1, 0, 1);
        rx = 1'b1;
        cyc(4);
        @(negedge ck);
        check_state("clr_vs_set");
        cyc(1);
        pop(DEP);
        do_clr();

        // reset during data bit 4 of 0xF0
        rx = 1'b0;
        cyc(D);
        for (int i = 0; i < 4; i++) begin
            rb = 8'hF0;
            rx = rb[i];
            cyc(D);
        end
        rx = 1'b1;
        cyc(D/2);
        rst = 1'b1;
        exp_q.delete();
        exp_frame = 1'b0;
        exp_ovf   = 1'b0;
        exp_par   = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(4);
        send_frame(8'h81, 1, 1, 0, 0);
        pop(1);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1, 1, 0, 0);
        send_frame(8'h07, 1, 0, 0, 0);
        pop(1);
        do_clr();
`endif

        // randomized traffic
        repeat (40) begin
            rb   = 8'($urandom_range(0, 255));
            s_ok = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
            p_ok = ($urandom_range(0, 5) != 0);
`else
            p_ok = 1'b1;
`endif
            send_frame(rb, s_ok, p_ok, 0, 0);
            if (!s_ok) begin
                cyc($urandom_range(1, 30));
                rx = 1'b1;
                cyc(3);
            end
            pop($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) do_clr();
        end
        pop(DEP);
        @(negedge ck);
        check_state("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
